// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and helpers for the multiply/divide unit.
//   - R-type func codes the MDU responds to
//   - divider FSM state encodings (2 bits)
//   - decoded operation enum, divider operand struct, abs helper
package mdu_pkg;

    localparam int DIV_ITERS = 32;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    localparam logic [1:0] MDU_IDLE = 2'b00;
    localparam logic [1:0] MDU_DIV  = 2'b01;
    localparam logic [1:0] MDU_DONE = 2'b10;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO
    } mdu_op_e;

    typedef struct packed {
        logic [31:0] dividend;
        logic [31:0] divisor;
    } div_opnd_t;

    function automatic mdu_op_e decode_func(input logic [5:0] f);
        case (f)
            FN_MULT:  return OP_MULT;
            FN_MULTU: return OP_MULTU;
            FN_DIV:   return OP_DIV;
            FN_DIVU:  return OP_DIVU;
            FN_MTHI:  return OP_MTHI;
            FN_MTLO:  return OP_MTLO;
            default:  return OP_NONE;
        endcase
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> MDU signal bundle.
//   en/func/A/B/flush : pipeline to MDU (instruction valid, func code,
//                       forwarded rs/rt operands, EX flush)
//   stall/busy/hi/lo  : MDU to pipeline (hold IF..EX, divider active,
//                       architectural HI/LO)
interface mdu_if;
    logic        en;
    logic [5:0]  func;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output en, func, A, B, flush,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  en, func, A, B, flush,
        output stall, busy, hi, lo
    );
endinterface

// File: rtl/mdu_div_radix2.sv
// div_radix2: radix-2 restoring divider datapath, one quotient bit per cycle.
//   clk, resetn : clock, async active-low reset
//   start_i     : load operands, clear remainder and counter
//   run_i       : perform one iteration this cycle
//   kill_i      : abandon the operation (counter and done flag cleared)
//   opnd_i      : unsigned dividend/divisor
//   quo_o/rem_o : quotient / remainder registers
//   last_o      : the iteration happening this cycle is the final one
//   done_o      : registered flag, high the cycle after the final iteration
module div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        run_i,
    input  logic        kill_i,
    input  div_opnd_t   opnd_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o,
    output logic        last_o,
    output logic        done_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;   // holds dividend bits, shifted out as quotient bits shift in
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        borrow;
    logic        diff_unused;

    // 33-bit trial subtraction; the borrow out is the rem>=divisor compare.
    assign rem_sh           = {rem_q, quo_q[31]};
    assign {borrow, diff}   = {1'b0, rem_sh} - {2'b00, dvs_q};
    // After a successful subtract the result is below the divisor, so its
    // top bit is always zero.
    assign diff_unused      = diff[32];

    assign last_o = run_i & (cnt_q == 5'(DIV_ITERS - 1));

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (kill_i) begin
            cnt_d = 5'd0;
        end else if (start_i) begin
            rem_d = 32'd0;
            quo_d = opnd_i.dividend;
            dvs_d = opnd_i.divisor;
            cnt_d = 5'd0;
        end else if (run_i) begin
            if (!borrow) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_sh[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d  = cnt_q + 5'd1;
            done_d = last_o;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            dvs_q  <= 32'd0;
            cnt_q  <= 5'd0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign done_o = done_q;

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit next to the EX-stage ALU; owns HI/LO.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : en/func/A/B/flush in; stall/busy/hi/lo out
// MULT/MULTU and MTHI/MTLO write at the next edge. DIV/DIVU run the
// IDLE -> DIV -> DONE -> IDLE sequence, stalling the pipeline from issue
// through the last iteration; HI/LO are written only on leaving DONE.
module mdu
    import mdu_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    mdu_if.slave bus
);

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        sa_q, sa_d;    // sign of dividend (0 for DIVU)
    logic        sb_q, sb_d;    // sign of divisor  (0 for DIVU)

    mdu_op_e     op;
    logic        idle_issue;
    logic        div_issue;
    logic        div_signed;
    div_opnd_t   div_opnd;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    logic [31:0] quo_raw, rem_raw;
    logic [31:0] quo_fix, rem_fix;
    logic        div_last, div_done;

    assign op         = bus.en ? decode_func(bus.func) : OP_NONE;
    assign idle_issue = !bus.flush && (state_q == MDU_IDLE);
    assign div_issue  = idle_issue && (op == OP_DIV || op == OP_DIVU);
    assign div_signed = (op == OP_DIV);

    assign div_opnd.dividend = div_signed ? abs32(bus.A) : bus.A;
    assign div_opnd.divisor  = div_signed ? abs32(bus.B) : bus.B;

    // Low 64 bits of a product of 64-bit extended operands equal the exact
    // 32x32 signed/unsigned product.
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    div_radix2 u_div (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (div_issue),
        .run_i   (!bus.flush && state_q == MDU_DIV),
        .kill_i  (bus.flush),
        .opnd_i  (div_opnd),
        .quo_o   (quo_raw),
        .rem_o   (rem_raw),
        .last_o  (div_last),
        .done_o  (div_done)
    );

    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000,
    // signs equal so no negation, remainder 0.
    assign quo_fix = (sa_q ^ sb_q) ? (~quo_raw + 32'd1) : quo_raw;
    assign rem_fix = sa_q ? (~rem_raw + 32'd1) : rem_raw;

    assign bus.stall = !bus.flush && (div_issue || state_q == MDU_DIV);
    assign bus.busy  = (state_q != MDU_IDLE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        case (state_q)
            MDU_IDLE: begin
                if (div_issue) begin
                    state_d = MDU_DIV;
                    sa_d    = div_signed & bus.A[31];
                    sb_d    = div_signed & bus.B[31];
                end
            end
            MDU_DIV:  if (div_last) state_d = MDU_DONE;
            // en/func ignored: the DIV still sitting in EX leaves this cycle.
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (bus.flush) state_d = MDU_IDLE;
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (idle_issue) begin
            case (op)
                OP_MULT:  {hi_d, lo_d} = prod_s;
                OP_MULTU: {hi_d, lo_d} = prod_u;
                OP_MTHI:  hi_d = bus.A;
                OP_MTLO:  lo_d = bus.A;
                default:  ;
            endcase
        end else if (!bus.flush && state_q == MDU_DONE && div_done) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MDU_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu. Stimulus pushes the expected HI/LO pair and
// the cycle it must first be visible; a negedge monitor pops an entry every
// time HI or LO changes and compares.
module tb_mdu;
    import mdu_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: any change of HI/LO is a write the scoreboard must account for.
    always @(negedge clk) begin
        if (mon_en && (bus.hi !== prev_hi || bus.lo !== prev_lo)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got hi=%h lo=%h expected no write", bus.hi, bus.lo);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_hi"},  bus.hi,    mon_e.hi);
                chk({mon_e.name, "_lo"},  bus.lo,    mon_e.lo);
                chk({mon_e.name, "_cyc"}, 32'(cyc),  32'(mon_e.cyc));
            end
            prev_hi = bus.hi;
            prev_lo = bus.lo;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                             input bit push, input logic [31:0] eh, input logic [31:0] el,
                             input string nm);
        bus.en = 1'b1; bus.func = f; bus.A = a; bus.B = b;
        if (push) sb_q.push_back(exp_t'{eh, el, cyc + 1, nm});
        #1;
        chk({nm, "_stall"}, 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.en = 1'b0;
    endtask

    // en stays high while stalled and through DONE, as the pipeline holds it.
    task automatic issue_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el, input string nm);
        int n;
        bus.en = 1'b1; bus.func = f; bus.A = a; bus.B = b;
        sb_q.push_back(exp_t'{eh, el, cyc + 34, nm});
        n = 0;
        #1;
        while (bus.stall && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        chk({nm, "_stall_cycles"}, 32'(n), 32'd33);
        chk({nm, "_busy_in_done"}, 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.func = 6'd0; bus.A = 32'd0; bus.B = 32'd0; bus.flush = 1'b0;
        #1 resetn = 1'b0;
        #20;
        chk("reset_hi",    bus.hi,           32'd0);
        chk("reset_lo",    bus.lo,           32'd0);
        chk("reset_stall", 32'(bus.stall),   32'd0);
        chk("reset_busy",  32'(bus.busy),    32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        step(1);

        // Reset in the middle of a divide
        issue_one(FN_MTHI, 32'hAAAA0000, 32'd0, 1'b1, 32'hAAAA0000, 32'd0, "mthi_pre");
        issue_one(FN_MTLO, 32'h00005555, 32'd0, 1'b1, 32'hAAAA0000, 32'h5555, "mtlo_pre");
        bus.en = 1'b1; bus.func = FN_DIV; bus.A = 32'd1000; bus.B = 32'd7;
        step(10);
        bus.en = 1'b0;
        sb_q.push_back(exp_t'{32'd0, 32'd0, cyc, "reset_mid_div"});
        resetn = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(bus.stall), 32'd0);
        chk("rst_mid_busy",  32'(bus.busy),  32'd0);
        step(2);
        resetn = 1'b1;
        #1;
        chk("rst_rel_busy",  32'(bus.busy),  32'd0);
        step(40);

        // Unmatched func: no write
        issue_one(6'b100000, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0, "unmatched");

        // Multiplies
        issue_one(FN_MULT,  32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        issue_one(FN_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h00000001, 32'hFFFFFFFE, "multu");

        // Divides
        issue_div(FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
        issue_div(FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
        issue_div(FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");
        issue_div(FN_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_by0");

        // Flush at iteration 5
        bus.en = 1'b1; bus.func = FN_DIV; bus.A = 32'd50; bus.B = 32'd3;
        step(5);
        chk("pre_flush_stall", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.en = 1'b0;
        #1;
        chk("flush_busy",       32'(bus.busy),  32'd0);
        chk("post_flush_stall", 32'(bus.stall), 32'd0);
        step(40);
        issue_one(FN_MTLO, 32'h00001234, 32'd0, 1'b1, 32'd7, 32'h1234, "mtlo_post_flush");

        // en held through DONE, then MTHI back-to-back
        issue_div(FN_DIV, 32'd1000, 32'hFFFFFFFD, 32'd1, 32'hFFFFFEB3, "div_hold");
        issue_one(FN_MTHI, 32'h0000CAFE, 32'd0, 1'b1, 32'h0000CAFE, 32'hFFFFFEB3, "mthi_b2b");
        step(40);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
